if_fetch_stage: RTL and testbench

//  Instruction-fetch stage plus IF/ID pipeline register for the cached ARM pipeline.

---
 rtl/if_fetch_stage.sv | 194 +++++++++++++++++++
 tb/tb_if_fetch_stage.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
//   Instruction-fetch stage and IF/ID pipeline register. Owns the PC, drives a
//   ready-handshaked instruction-memory port, parks a fetched word in a
//   one-entry skid buffer while the pipeline is frozen, and redirects on taken
//   branches. A response already in flight when a branch resolves is dropped.
//
//   Optional build macro: IF_PERF_CNT_EN adds perf_fetch_cnt / perf_stall_cnt.
//
// Ports
//   clk            in   system clock, all state on posedge
//   rst            in   asynchronous, active-low reset
//   hazard_detect  in   ID hazard; freeze PC and IF/ID
//   mem_freeze     in   global memory stall; freeze the whole stage
//   branch_taken   in   taken branch resolved in EXE
//   branch_addr    in   branch target
//   imem_req       out  fetch request, held until imem_ready
//   imem_addr      out  fetch address (= pc)
//   imem_ready     in   imem_rdata valid this cycle
//   imem_rdata     in   fetched instruction
//   if_id_valid    out  IF/ID holds a real instruction
//   if_id_pc       out  fetch PC + 4 of the held instruction
//   if_id_instr    out  held instruction, 0 when invalid
//   perf_fetch_cnt out  (IF_PERF_CNT_EN) instructions written to IF/ID
//   perf_stall_cnt out  (IF_PERF_CNT_EN) stalled cycles outside DROP
// ---------------------------------------------------------------------------
module if_fetch_stage #(
  parameter int unsigned          ADDR_W   = 32,
  parameter int unsigned          INSTR_W  = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hazard_detect,
  input  logic               mem_freeze,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_addr,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_id_valid,
  output logic [ADDR_W-1:0]  if_id_pc,
  output logic [INSTR_W-1:0] if_id_instr
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DROP  = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  pc, pc_nxt;
  logic [ADDR_W-1:0]  redir, redir_nxt;
  logic [INSTR_W-1:0] skid, skid_nxt;
  logic               req_nxt;
  logic               valid_nxt;
  logic [ADDR_W-1:0]  id_pc_nxt;
  logic [INSTR_W-1:0] id_instr_nxt;

  logic stall;
  logic branch_eff;

  // mem_freeze masks branches; hazard alone still lets branches through.
  assign stall      = hazard_detect | mem_freeze;
  assign branch_eff = branch_taken & ~mem_freeze;

  assign imem_addr = pc;

  // Next-state and register-update logic.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    redir_nxt    = redir;
    skid_nxt     = skid;
    valid_nxt    = if_id_valid;
    id_pc_nxt    = if_id_pc;
    id_instr_nxt = if_id_instr;

    if (branch_eff) begin
      valid_nxt    = 1'b0;
      id_pc_nxt    = '0;
      id_instr_nxt = '0;
    end

    unique case (state)
      ST_FETCH: begin
        if (branch_eff) begin
          if (imem_ready) begin
            pc_nxt = branch_addr;
          end else begin
            redir_nxt = branch_addr;
            state_nxt = ST_DROP;
          end
        end else if (imem_ready) begin
          pc_nxt = pc + ADDR_W'(4);
          if (stall) begin
            skid_nxt  = imem_rdata;
            state_nxt = ST_HOLD;
          end else begin
            valid_nxt    = 1'b1;
            id_pc_nxt    = pc + ADDR_W'(4);
            id_instr_nxt = imem_rdata;
          end
        end
      end

      ST_HOLD: begin
        // pc already advanced past the skid word, so it equals skid PC + 4.
        if (branch_eff) begin
          skid_nxt  = '0;
          pc_nxt    = branch_addr;
          state_nxt = ST_FETCH;
        end else if (!stall) begin
          valid_nxt    = 1'b1;
          id_pc_nxt    = pc;
          id_instr_nxt = skid;
          state_nxt    = ST_FETCH;
        end
      end

      ST_DROP: begin
        // Latest branch wins; the stale response is discarded on arrival.
        if (branch_eff) begin
          redir_nxt = branch_addr;
        end
        if (imem_ready) begin
          pc_nxt    = branch_eff ? branch_addr : redir;
          state_nxt = ST_FETCH;
        end
      end

      default: begin
        state_nxt = ST_FETCH;
      end
    endcase

    req_nxt = (state_nxt != ST_HOLD);
  end

  // State and pipeline registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_FETCH;
      pc          <= RESET_PC;
      redir       <= '0;
      skid        <= '0;
      imem_req    <= 1'b1;
      if_id_valid <= 1'b0;
      if_id_pc    <= '0;
      if_id_instr <= '0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      redir       <= redir_nxt;
      skid        <= skid_nxt;
      imem_req    <= req_nxt;
      if_id_valid <= valid_nxt;
      if_id_pc    <= id_pc_nxt;
      if_id_instr <= id_instr_nxt;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic fetch_load;

  // Instruction written into IF/ID from memory or from the skid buffer.
  assign fetch_load = ~branch_eff &
                      (((state == ST_FETCH) & imem_ready & ~stall) |
                       ((state == ST_HOLD) & ~stall));

  // Free-running performance counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (fetch_load) begin
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      end
      if (stall && (state != ST_DROP)) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_stage
//   Directed scenarios followed by randomized traffic, all checked every cycle
//   against a transaction-level model of the fetch stage. The model tracks a
//   pending redirect and a parked instruction as queues instead of a state.
// ---------------------------------------------------------------------------
module tb_if_fetch_stage;

  logic        clk;
  logic        rst;
  logic        hazard_detect;
  logic        mem_freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;

  int checks;
  int failures;

  // Reference model.
  logic [31:0] m_pc;
  logic [31:0] m_parked[$];
  logic [31:0] m_redirect[$];
  logic        e_valid;
  logic [31:0] e_pc;
  logic [31:0] e_instr;

  if_fetch_stage #(
    .ADDR_W  (32),
    .INSTR_W (32),
    .RESET_PC(32'h0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .hazard_detect(hazard_detect),
    .mem_freeze   (mem_freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .if_id_valid  (if_id_valid),
    .if_id_pc     (if_id_pc),
    .if_id_instr  (if_id_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_at(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hE1A0_0000;
  endfunction

  function automatic logic model_req();
    return (m_parked.size() == 0);
  endfunction

  task automatic model_reset();
    m_pc = 32'h0;
    m_parked.delete();
    m_redirect.delete();
    e_valid = 1'b0;
    e_pc    = 32'h0;
    e_instr = 32'h0;
  endtask

  task automatic model_flush();
    e_valid = 1'b0;
    e_pc    = 32'h0;
    e_instr = 32'h0;
  endtask

  // One clock of architectural behaviour.
  task automatic model_step(input logic hz, input logic mf, input logic br,
                            input logic [31:0] ba, input logic rdy,
                            input logic [31:0] rd);
    logic stall;
    logic brk;
    stall = hz | mf;
    brk   = br & ~mf;
    if (m_redirect.size() > 0) begin
      if (brk) begin
        m_redirect[0] = ba;
        model_flush();
      end
      if (rdy) m_pc = m_redirect.pop_front();
    end else if (m_parked.size() > 0) begin
      if (brk) begin
        m_parked.delete();
        m_pc = ba;
        model_flush();
      end else if (!stall) begin
        e_valid = 1'b1;
        e_pc    = m_pc;
        e_instr = m_parked.pop_front();
      end
    end else begin
      if (brk) begin
        model_flush();
        if (rdy) m_pc = ba;
        else     m_redirect.push_back(ba);
      end else if (rdy) begin
        if (stall) begin
          m_parked.push_back(rd);
        end else begin
          e_valid = 1'b1;
          e_pc    = m_pc + 32'd4;
          e_instr = rd;
        end
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".imem_req"},    32'(imem_req),    32'(model_req()));
    check({tag, ".imem_addr"},   imem_addr,        m_pc);
    check({tag, ".if_id_valid"}, 32'(if_id_valid), 32'(e_valid));
    check({tag, ".if_id_pc"},    if_id_pc,         e_pc);
    check({tag, ".if_id_instr"}, if_id_instr,      e_instr);
  endtask

  // Drive one cycle of inputs; the memory only answers an active request.
  task automatic cyc(input string tag, input logic hz, input logic mf,
                     input logic br, input logic [31:0] ba, input logic rdy);
    logic        r;
    logic [31:0] rd;
    r  = rdy & model_req();
    rd = instr_at(m_pc);
    hazard_detect = hz;
    mem_freeze    = mf;
    branch_taken  = br;
    branch_addr   = ba;
    imem_ready    = r;
    imem_rdata    = rd;
    @(posedge clk);
    model_step(hz, mf, br, ba, r, rd);
    #1;
    check_all(tag);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst           = 1'b0;
    hazard_detect = 1'b0;
    mem_freeze    = 1'b0;
    branch_taken  = 1'b0;
    branch_addr   = 32'h0;
    imem_ready    = 1'b0;
    imem_rdata    = 32'h0;
    model_reset();

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b1;

    // Streaming fetch with a zero-wait memory.
    cyc("stream0", 0, 0, 0, 32'h0, 1);
    cyc("stream1", 0, 0, 0, 32'h0, 1);

    // Hazard at pc=8 for two cycles: word parks in skid, then resumes.
    cyc("hazard0", 1, 0, 0, 32'h0, 1);
    cyc("hazard1", 1, 0, 0, 32'h0, 1);
    cyc("resume0", 0, 0, 0, 32'h0, 1);
    cyc("resume1", 0, 0, 0, 32'h0, 1);

    // Branch to 0x100 while the memory is waiting; stale response dropped.
    cyc("brwait0", 0, 0, 1, 32'h100, 0);
    cyc("brwait1", 0, 0, 0, 32'h0, 0);
    cyc("brwait2", 0, 0, 0, 32'h0, 0);
    cyc("brdrop",  0, 0, 0, 32'h0, 1);
    cyc("brtgt",   0, 0, 0, 32'h0, 1);

    // mem_freeze with branch held: nothing moves until release.
    for (int i = 0; i < 5; i++) cyc("freeze", 0, 1, 1, 32'h200, 0);
    cyc("frzrel",  0, 0, 1, 32'h200, 1);
    cyc("frzpost", 0, 0, 0, 32'h0, 1);

    // Address wrap at the top of memory.
    cyc("wrapbr",  0, 0, 1, 32'hFFFF_FFFC, 1);
    cyc("wrap",    0, 0, 0, 32'h0, 1);
    cyc("wrap1",   0, 0, 0, 32'h0, 1);

    // Reset asserted while a redirect is pending.
    cyc("rstdrop", 0, 0, 1, 32'h300, 0);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_all("rst_async");
    imem_ready = 1'b1;
    imem_rdata = instr_at(32'h300);
    @(posedge clk);
    #1;
    check_all("rst_hold");
    rst = 1'b1;
    cyc("rst_rel0", 0, 0, 0, 32'h0, 1);
    cyc("rst_rel1", 0, 0, 0, 32'h0, 1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic        hz;
      logic        mf;
      logic        br;
      logic        rdy;
      logic [31:0] ba;
      hz  = ($urandom_range(0, 99) < 20);
      mf  = ($urandom_range(0, 99) < 10);
      br  = ($urandom_range(0, 99) < 10);
      rdy = ($urandom_range(0, 99) < 60);
      ba  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC))
                                       : ($urandom & 32'h0000_FFFC);
      cyc("rand", hz, mf, br, ba, rdy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
